cali_sequencer: RTL

//  Parametrised DDR calibration sequencer between the init/config logic and the DFI PHY.
//  On a start request it holds DRAM reset and waits for PHY init.
//  It then runs per-lane write leveling and read leveling with timeouts, and reports

---
 rtl/cali_sequencer.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/cali_sequencer.sv
// DDR calibration sequencer: DRAM reset hold, PHY init, then per-lane write/read leveling
// with timeouts and a per-lane fail report. Read leveling exists only with CALI_RDLVL_EN defined.
module cali_sequencer #(
  parameter int LANES      = 4,
  parameter int CNT_W      = 16,
  parameter int STROBE_PER = 8
) (
  input  logic             core_clk,
  input  logic             core_arst,
  input  logic             cali_start,
  input  logic [CNT_W-1:0] cfg_rst_cycles,
  input  logic [CNT_W-1:0] cfg_timeout,
  output logic             cali_busy,
  output logic             cali_done,
  output logic             cali_fail,
  output logic [LANES-1:0] cali_fail_lanes,
  output logic [2:0]       cali_phase,
  output logic             dfi_reset_n,
  output logic             dfi_init_start,
  input  logic             dfi_init_complete,
  output logic [LANES-1:0] dfi_wrlvl_en,
  output logic [LANES-1:0] dfi_wrlvl_strobe,
  input  logic [LANES-1:0] dfi_wrlvl_resp,
  output logic [LANES-1:0] dfi_rdlvl_en,
  input  logic [LANES-1:0] dfi_rdlvl_resp
);

  localparam int                SW        = $clog2(STROBE_PER);
  localparam logic [SW-1:0]     STRB_LAST = SW'(STROBE_PER - 1);
  localparam logic [LANES-1:0]  ALL_LANES = {LANES{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RST_HOLD  = 3'd1,
    S_INIT_WAIT = 3'd2,
    S_WL        = 3'd3,
    S_RL        = 3'd4,
    S_DONE      = 3'd5,
    S_FAIL      = 3'd6
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]      strb_q, strb_d;
  logic [LANES-1:0]   sticky_q, sticky_d;
  logic [LANES-1:0]   flanes_q, flanes_d;
  logic               start_q;
  logic [CNT_W-1:0]   rst_cyc_q, tmo_q;

  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               fail_q, fail_d;
  logic [LANES-1:0]   flo_q, flo_d;
  logic [2:0]         phase_q, phase_d;
  logic               rstn_q, rstn_d;
  logic               init_q, init_d;
  logic [LANES-1:0]   wlen_q, wlen_d;
  logic [LANES-1:0]   wstb_q, wstb_d;
  logic [LANES-1:0]   rden_q, rden_d;

  logic               start;
  logic               idle_like;
  logic               timeout;
  logic               leave;
  logic [CNT_W-1:0]   rst_last;
  logic [LANES-1:0]   lane_hit;

`ifndef CALI_RDLVL_EN
  logic unused_rdlvl_resp;
  assign unused_rdlvl_resp = ^dfi_rdlvl_resp;
`endif

  always_comb begin
    start     = cali_start & ~start_q;
    idle_like = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_FAIL);
    timeout   = (tmo_q != '0) && (cnt_q == tmo_q - CNT_W'(1));
    rst_last  = (rst_cyc_q == '0) ? '0 : rst_cyc_q - CNT_W'(1);
    lane_hit  = sticky_q;
    state_d   = state_q;
    flanes_d  = flanes_q;

    // Completion is tested before timeout so a response in the timeout cycle still passes.
    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start) begin
          state_d  = S_RST_HOLD;
          flanes_d = '0;
        end
      end
      S_RST_HOLD: begin
        if (cnt_q == rst_last) state_d = S_INIT_WAIT;
      end
      S_INIT_WAIT: begin
        if (dfi_init_complete) begin
          state_d = S_WL;
        end else if (timeout) begin
          state_d  = S_FAIL;
          flanes_d = ALL_LANES;
        end
      end
      S_WL: begin
        lane_hit = sticky_q | dfi_wrlvl_resp;
        if (&lane_hit) begin
`ifdef CALI_RDLVL_EN
          state_d = S_RL;
`else
          state_d = S_DONE;
`endif
        end else if (timeout) begin
          state_d  = S_FAIL;
          flanes_d = ~lane_hit;
        end
      end
`ifdef CALI_RDLVL_EN
      S_RL: begin
        lane_hit = sticky_q | dfi_rdlvl_resp;
        if (&lane_hit) begin
          state_d = S_DONE;
        end else if (timeout) begin
          state_d  = S_FAIL;
          flanes_d = ~lane_hit;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    leave    = (state_d != state_q);
    sticky_d = leave ? '0 : lane_hit;
    cnt_d    = leave ? '0 : ((&cnt_q) ? cnt_q : cnt_q + CNT_W'(1));
    strb_d   = (leave || (strb_q == STRB_LAST)) ? '0 : strb_q + SW'(1);

    // Outputs are a registered image of the current state, one cycle behind it.
    busy_d  = ~idle_like;
    done_d  = (state_q == S_DONE);
    fail_d  = (state_q == S_FAIL);
    flo_d   = (state_q == S_FAIL) ? flanes_q : '0;
    phase_d = state_q;
    rstn_d  = (state_q != S_RST_HOLD);
    init_d  = (state_q == S_INIT_WAIT);
    wlen_d  = (state_q == S_WL) ? ALL_LANES : '0;
    wstb_d  = ((state_q == S_WL) && (strb_q == '0)) ? ~lane_hit : '0;
`ifdef CALI_RDLVL_EN
    rden_d  = (state_q == S_RL) ? ~lane_hit : '0;
`else
    rden_d  = '0;
`endif
  end

  always_ff @(posedge core_clk or posedge core_arst) begin
    if (core_arst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      strb_q   <= '0;
      sticky_q <= '0;
      flanes_q <= '0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fail_q   <= 1'b0;
      flo_q    <= '0;
      phase_q  <= 3'd0;
      rstn_q   <= 1'b1;
      init_q   <= 1'b0;
      wlen_q   <= '0;
      wstb_q   <= '0;
      rden_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      strb_q   <= strb_d;
      sticky_q <= sticky_d;
      flanes_q <= flanes_d;
      start_q  <= cali_start;
      busy_q   <= busy_d;
      done_q   <= done_d;
      fail_q   <= fail_d;
      flo_q    <= flo_d;
      phase_q  <= phase_d;
      rstn_q   <= rstn_d;
      init_q   <= init_d;
      wlen_q   <= wlen_d;
      wstb_q   <= wstb_d;
      rden_q   <= rden_d;
    end
  end

  // Run configuration is only consumed outside IDLE, so it needs no reset.
  always_ff @(posedge core_clk) begin
    if (start && idle_like) begin
      rst_cyc_q <= cfg_rst_cycles;
      tmo_q     <= cfg_timeout;
    end
  end

  assign cali_busy        = busy_q;
  assign cali_done        = done_q;
  assign cali_fail        = fail_q;
  assign cali_fail_lanes  = flo_q;
  assign cali_phase       = phase_q;
  assign dfi_reset_n      = rstn_q;
  assign dfi_init_start   = init_q;
  assign dfi_wrlvl_en     = wlen_q;
  assign dfi_wrlvl_strobe = wstb_q;
  assign dfi_rdlvl_en     = rden_q;

endmodule
